vga_frame_reader: RTL and testbench

Reads the 320x240 RGB444 frame buffer that camera capture fills, and drives a 640x480@60 VGA output with 2x pixel and line duplication. It sits on the BRAM read port, opposite the capture write port, in the display clock domain. It generates VGA timing and linear read addresses, and compensates for BRAM read latency so that syncs, data-enable and colour leave aligned.

---
 rtl/vga_frame_reader.sv | 136 +++++++++++++
 tb/tb_vga_frame_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// VGA 640x480 scan-out from a 320x240 RGB444 frame buffer with 2x pixel/line duplication.
// Sync, data-enable and frame marker are delayed to line up with the BRAM read latency.
module vga_frame_reader #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   SRC_W       = 320,
  parameter int   RD_LATENCY  = 1,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [16:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DEPTH   = RD_LATENCY + 1;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [16:0]   LINE_STEP = 17'(SRC_W);

  logic [HW-1:0]    r_h_cnt;
  logic [VW-1:0]    r_v_cnt;
  logic [16:0]      r_line_base;
  logic [DEPTH-1:0] r_act_pipe;
  logic [DEPTH-1:0] r_hs_pipe;
  logic [DEPTH-1:0] r_vs_pipe;
  logic [DEPTH-1:0] r_fs_pipe;

  logic        w_active;
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_frame;
  logic        w_line_end;
  logic        w_last_line;
  logic [16:0] w_pix_addr;

  assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_on     = (r_h_cnt >= H_SS) && (r_h_cnt <= H_SE);
  assign w_vs_on     = (r_v_cnt >= V_SS) && (r_v_cnt <= V_SE);
  assign w_frame     = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_last_line = (r_v_cnt == V_LAST);
  // Horizontal duplication: drop the LSB of the display column.
  assign w_pix_addr  = r_line_base + 17'(r_h_cnt[HW-1:1]);

  // Raster counters; line_base steps after each odd active line for vertical duplication.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_base <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      if (w_last_line) begin
        r_v_cnt     <= '0;
        r_line_base <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
        if ((r_v_cnt < V_ACT) && r_v_cnt[0])
          r_line_base <= r_line_base + LINE_STEP;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= w_active;
      if (w_active)
        rd_addr <= w_pix_addr;
    end
  end

  // Sync flags travel active-high through the pipe; polarity is applied at the pins.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_act_pipe <= '0;
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
      r_fs_pipe  <= '0;
    end else begin
      r_act_pipe <= {r_act_pipe[DEPTH-2:0], w_active};
      r_hs_pipe  <= {r_hs_pipe[DEPTH-2:0],  w_hs_on};
      r_vs_pipe  <= {r_vs_pipe[DEPTH-2:0],  w_vs_on};
      r_fs_pipe  <= {r_fs_pipe[DEPTH-2:0],  w_frame};
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      de          <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      de          <= r_act_pipe[DEPTH-1];
      {vga_r, vga_g, vga_b} <= r_act_pipe[DEPTH-1] ? rd_data : '0;
      hsync       <= r_hs_pipe[DEPTH-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= r_vs_pipe[DEPTH-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= r_fs_pipe[DEPTH-1];
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: one full-size instance plus two reduced-geometry instances
// (read latency 1 and 3) compared cycle by cycle against a raster-position model.
module tb_vga_frame_reader;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int srcw;
  } geom_t;

  localparam int N = 3;

  logic        pclk;
  logic        rst_n;
  logic [16:0] addr_w [N];
  logic        en_w   [N];
  logic [11:0] rdd_w  [N];
  logic [3:0]  r_w    [N];
  logic [3:0]  g_w    [N];
  logic [3:0]  b_w    [N];
  logic        hs_w   [N];
  logic        vs_w   [N];
  logic        de_w   [N];
  logic        fs_w   [N];

  logic [11:0] mem [0:76799];
  logic [11:0] bq0, bq1;

  geom_t       geo [N];
  int          dly [N];
  logic [16:0] held [N];
  int          k;
  int          checks;
  int          failures;
  int          last_fs;
  int          max_addr;
  logic [15:0] hist [2];

  vga_frame_reader u_full (
    .pclk(pclk), .rst_n(rst_n), .rd_addr(addr_w[0]), .rd_en(en_w[0]), .rd_data(rdd_w[0]),
    .vga_r(r_w[0]), .vga_g(g_w[0]), .vga_b(b_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
    .de(de_w[0]), .frame_start(fs_w[0]));

  vga_frame_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SRC_W(8), .RD_LATENCY(1)
  ) u_small1 (
    .pclk(pclk), .rst_n(rst_n), .rd_addr(addr_w[1]), .rd_en(en_w[1]), .rd_data(rdd_w[1]),
    .vga_r(r_w[1]), .vga_g(g_w[1]), .vga_b(b_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
    .de(de_w[1]), .frame_start(fs_w[1]));

  vga_frame_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SRC_W(8), .RD_LATENCY(3)
  ) u_small3 (
    .pclk(pclk), .rst_n(rst_n), .rd_addr(addr_w[2]), .rd_en(en_w[2]), .rd_data(rdd_w[2]),
    .vga_r(r_w[2]), .vga_g(g_w[2]), .vga_b(b_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]),
    .de(de_w[2]), .frame_start(fs_w[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // BRAM models; idle reads return all-ones so blanking must mask them.
  always @(posedge pclk) begin
    rdd_w[0] <= en_w[0] ? mem[addr_w[0]] : 12'hFFF;
    rdd_w[1] <= en_w[1] ? mem[addr_w[1]] : 12'hFFF;
    bq0      <= en_w[2] ? mem[addr_w[2]] : 12'hFFF;
    bq1      <= bq0;
    rdd_w[2] <= bq1;
  end

  function automatic int htot(geom_t g); return g.ha + g.hf + g.hs + g.hb; endfunction
  function automatic int vtot(geom_t g); return g.va + g.vf + g.vs + g.vb; endfunction
  function automatic int hpos(geom_t g, int p); return p % htot(g); endfunction
  function automatic int vpos(geom_t g, int p); return (p / htot(g)) % vtot(g); endfunction

  function automatic bit is_act(geom_t g, int p);
    return (hpos(g, p) < g.ha) && (vpos(g, p) < g.va);
  endfunction

  function automatic int addr_of(geom_t g, int p);
    return (vpos(g, p) / 2) * g.srcw + hpos(g, p) / 2;
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d k=%0d observed=%0h expected=%0h", tag, d, k, obs, exp);
    end
  endtask

  task automatic check_all();
    int q;
    bit a;
    logic [11:0] rgb;
    for (int d = 0; d < N; d++) begin
      chk("rd_en", d, 32'(en_w[d]), 32'((k >= 1) && is_act(geo[d], k - 1)));
      chk("rd_addr", d, 32'(addr_w[d]), 32'(held[d]));
      q = k - dly[d];
      a = (q >= 0) && is_act(geo[d], q);
      rgb = a ? mem[addr_of(geo[d], q)] : 12'h000;
      chk("de", d, 32'(de_w[d]), 32'(a));
      chk("rgb", d, 32'({r_w[d], g_w[d], b_w[d]}), 32'(rgb));
      chk("hsync", d, 32'(hs_w[d]), 32'(!((q >= 0) && hpos(geo[d], q) >= geo[d].ha + geo[d].hf
                                         && hpos(geo[d], q) < geo[d].ha + geo[d].hf + geo[d].hs)));
      chk("vsync", d, 32'(vs_w[d]), 32'(!((q >= 0) && vpos(geo[d], q) >= geo[d].va + geo[d].vf
                                         && vpos(geo[d], q) < geo[d].va + geo[d].vf + geo[d].vs)));
      chk("frame_start", d, 32'(fs_w[d]), 32'((q >= 0) && (q % (htot(geo[d]) * vtot(geo[d])) == 0)));
    end
    // Latency-3 build must reproduce the latency-1 stream two cycles later.
    if (k >= 2)
      chk("lat_shift", 2, 32'({de_w[2], r_w[2], g_w[2], b_w[2], hs_w[2], vs_w[2], fs_w[2]}), 32'(hist[1]));
    hist[1] = hist[0];
    hist[0] = {de_w[1], r_w[1], g_w[1], b_w[1], hs_w[1], vs_w[1], fs_w[1]};
    if (fs_w[1] === 1'b1) begin
      if (last_fs >= 0)
        chk("fs_spacing", 1, 32'(k - last_fs), 32'(htot(geo[1]) * vtot(geo[1])));
      last_fs = k;
    end
    if (en_w[1] === 1'b1 && int'(addr_w[1]) > max_addr)
      max_addr = int'(addr_w[1]);
  endtask

  task automatic step();
    @(posedge pclk);
    if (!rst_n) begin
      k = 0;
      last_fs = -1;
      for (int d = 0; d < N; d++) held[d] = '0;
    end else begin
      k++;
      for (int d = 0; d < N; d++)
        if (is_act(geo[d], k - 1)) held[d] = 17'(addr_of(geo[d], k - 1));
    end
    #1;
    check_all();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    last_fs  = -1;
    max_addr = -1;
    hist[0]  = '0;
    hist[1]  = '0;
    geo[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, srcw: 320};
    geo[1] = '{ha: 16, hf: 2, hs: 3, hb: 3, va: 12, vf: 2, vs: 2, vb: 2, srcw: 8};
    geo[2] = geo[1];
    dly[0] = 3;
    dly[1] = 3;
    dly[2] = 5;
    for (int i = 0; i < 76800; i++) mem[i] = 12'($urandom);
    for (int d = 0; d < N; d++) held[d] = '0;

    rst_n = 1'b0;
    repeat (5) step();

    rst_n = 1'b1;
    repeat (400 + $urandom_range(0, 40)) step();

    // Reset mid-line on the full-size raster.
    rst_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (2700) step();

    // Reset mid-frame: full-size at line 3, reduced raster inside its active area.
    rst_n = 1'b0;
    repeat ($urandom_range(1, 4)) step();
    rst_n = 1'b1;
    repeat (1500) step();

    chk("max_addr", 1, 32'(max_addr), 32'((geo[1].va / 2 - 1) * geo[1].srcw + geo[1].srcw - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
